sci_uart: RTL and testbench

Register-mapped 8N1 UART peripheral: the responder on the 4-register SCI host bus (`scisel`/`rw`/`addr`/`dbus`) that the host-side interface controller drives. It serializes bytes written by the host onto `txd`, deserializes `rxd` into a receive data register, and raises `sciirq` from status flags. It sits between the host-side controller and the board pins.

---
 rtl/sci_uart.sv | 211 +++++++++++++++++++++
 tb/tb_sci_uart.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sci_uart.sv
// rtl/sci_uart.sv - register-mapped 8N1 UART responder on the SCI host bus
module sci_uart #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       scisel,
    input  logic       rw,
    input  logic [1:0] addr,
    inout  wire  [7:0] dbus,
    input  logic       rxd,
    output logic       txd,
    output logic       sciirq
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;

    tx_state_t     tx_state_q, tx_state_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tdr_q, tdr_d;
    logic          tdre_q, tdre_d;
    logic          tc_q, tc_d;

    rx_state_t     rx_state_q, rx_state_d;
    logic          rx_s1_q, rx_s2_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rdr_q, rdr_d;
    logic          rdrf_q, rdrf_d;
    logic          or_q, or_d;
    logic          fe_q, fe_d;
    logic [7:0]    ctrl_q, ctrl_d;

    logic          wr_tdr, wr_ctrl, rd_rdr;
    logic          tx_bit_end, tx_frame_end, tx_load;
    logic          rx_done;
    logic [7:0]    rd_data;

    assign wr_tdr  = scisel && rw && (addr == 2'b01);
    assign wr_ctrl = scisel && rw && (addr == 2'b11);
    assign rd_rdr  = scisel && !rw && (addr == 2'b00);

    assign tx_bit_end   = (tx_state_q == TX_SHIFT) && (tx_cnt_q == CNT_LAST);
    assign tx_frame_end = tx_bit_end && (tx_bit_q == 4'd9);
    // A pending byte starts from idle, or chains directly onto the end of the stop bit
    assign tx_load      = !tdre_q && ((tx_state_q == TX_IDLE) || tx_frame_end);
    assign rx_done      = (rx_state_q == RX_STOP) && (rx_cnt_q == CNT_LAST);

    assign txd    = tx_shift_q[0];
    assign sciirq = (ctrl_q[6] && rdrf_q) || (ctrl_q[7] && tdre_q);

    // Zero-wait-state read mux; unused STATUS bits read 0
    always_comb begin
        rd_data = 8'h00;
        case (addr)
            2'b00:   rd_data = rdr_q;
            2'b10:   rd_data = {tdre_q, tc_q, rdrf_q, 1'b0, or_q, 1'b0, fe_q, 1'b0};
            2'b11:   rd_data = ctrl_q;
            default: rd_data = 8'h00;
        endcase
    end

    assign dbus = (scisel && !rw) ? rd_data : 8'bz;

    // State register for both FSMs, datapath and flags; shifter resets to ones so txd idles high
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= 10'h3FF;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 4'd0;
            tdr_q      <= 8'h00;
            tdre_q     <= 1'b1;
            tc_q       <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rdr_q      <= 8'h00;
            rdrf_q     <= 1'b0;
            or_q       <= 1'b0;
            fe_q       <= 1'b0;
            ctrl_q     <= 8'h00;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tdr_q      <= tdr_d;
            tdre_q     <= tdre_d;
            tc_q       <= tc_d;
            rx_state_q <= rx_state_d;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rdr_q      <= rdr_d;
            rdrf_q     <= rdrf_d;
            or_q       <= or_d;
            fe_q       <= fe_d;
            ctrl_q     <= ctrl_d;
        end
    end

    // Transmitter next state: leave idle on a pending byte, return only when nothing is pending
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE:  if (!tdre_q) tx_state_d = TX_SHIFT;
            TX_SHIFT: if (tx_frame_end && tdre_q) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    // Transmitter datapath: TDR capture, frame load, per-bit shift and TC
    always_comb begin
        tdr_d      = tdr_q;
        tdre_d     = tdre_q;
        tc_d       = tc_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        if (wr_tdr && tdre_q) begin
            tdr_d  = dbus;
            tdre_d = 1'b0;
        end
        if (tx_load) begin
            tx_shift_d = {1'b1, tdr_q, 1'b0};
            tx_cnt_d   = '0;
            tx_bit_d   = 4'd0;
            tdre_d     = 1'b1;
            tc_d       = 1'b0;
        end else if (tx_state_q == TX_SHIFT) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
            if (tx_bit_end) begin
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                tx_bit_d   = tx_frame_end ? 4'd0 : tx_bit_q + 4'd1;
            end
            if (tx_frame_end) tc_d = 1'b1;
        end
    end

    // Receiver next state: start validation, 8 data bits, stop, and break wait
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:   if (!rx_s2_q) rx_state_d = RX_START;
            RX_START:  if (rx_cnt_q == CNT_HALF) rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_cnt_q == CNT_LAST && rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:   if (rx_cnt_q == CNT_LAST) rx_state_d = rx_s2_q ? RX_IDLE : RX_WAITHI;
            RX_WAITHI: if (rx_s2_q) rx_state_d = RX_IDLE;
            default:   rx_state_d = RX_IDLE;
        endcase
    end

    // Receiver datapath: bit timing counter and LSB-first sampling
    always_comb begin
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            RX_START: if (rx_cnt_q == CNT_HALF) rx_cnt_d = '0;
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RX_STOP:  if (rx_cnt_q == CNT_LAST) rx_cnt_d = '0;
            default: begin
                rx_cnt_d = '0;
                rx_bit_d = 3'd0;
            end
        endcase
    end

    // Receive flags and CTRL: a completion on the same edge as an RDR read keeps the new byte
    always_comb begin
        rdr_d  = rdr_q;
        rdrf_d = rdrf_q;
        or_d   = or_q;
        fe_d   = fe_q;
        ctrl_d = wr_ctrl ? dbus : ctrl_q;
        if (rd_rdr) begin
            rdrf_d = 1'b0;
            or_d   = 1'b0;
            fe_d   = 1'b0;
        end
        if (rx_done) begin
            if (!rdrf_q || rd_rdr) begin
                rdr_d  = rx_shift_q;
                rdrf_d = 1'b1;
                fe_d   = !rx_s2_q;
            end else begin
                or_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sci_uart.sv
// tb/tb_sci_uart.sv - randomized and directed bench for sci_uart against a frame-level model
module tb_sci_uart;
    localparam int B = 8;

    logic       clk = 1'b0;
    logic       rstb;
    logic       scisel;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] db_drv;
    logic       db_oe;
    wire  [7:0] dbus;
    logic       rxd;
    logic       txd;
    logic       sciirq;

    assign dbus = db_oe ? db_drv : 8'bz;

    sci_uart #(.BAUD_DIV(B)) dut (
        .clk    (clk),
        .rstb   (rstb),
        .scisel (scisel),
        .rw     (rw),
        .addr   (addr),
        .dbus   (dbus),
        .rxd    (rxd),
        .txd    (txd),
        .sciirq (sciirq)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [7:0] b;
        logic       s;
    } comp_t;

    int         cyc;
    int         n_checks;
    int         n_fail;
    bit         checking;
    bit         rx_phase_done;
    logic [7:0] m_ctrl, m_rdr, m_tdr, tx_byte;
    logic       m_rdrf, m_or, m_fe, m_tdre, m_tc, tx_busy;
    int         tx_start, tx_end;
    comp_t      rx_q[$];
    int         last_comp, last_n0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 8'h00; m_rdr = 8'h00; m_tdr = 8'h00; tx_byte = 8'h00;
        m_rdrf = 1'b0; m_or = 1'b0; m_fe = 1'b0;
        m_tdre = 1'b1; m_tc = 1'b1; tx_busy = 1'b0;
        tx_start = 0; tx_end = 0;
        rx_q.delete();
    endtask

    task automatic model_edge();
        logic prev_tdre, rd0, wtdr, wctrl, comp;
        comp_t c;
        cyc++;
        prev_tdre = m_tdre;
        rd0   = scisel && !rw && (addr == 2'd0);
        wtdr  = scisel && rw && (addr == 2'd1);
        wctrl = scisel && rw && (addr == 2'd3);
        // transmitter: frames of 10*B cycles, next byte chains without gap
        if (tx_busy && cyc == tx_end) tx_busy = 1'b0;
        if (!prev_tdre && !tx_busy) begin
            tx_busy  = 1'b1;
            tx_start = cyc;
            tx_end   = cyc + 10 * B;
            tx_byte  = m_tdr;
            m_tdre   = 1'b1;
            m_tc     = 1'b0;
        end else if (!tx_busy) begin
            m_tc = 1'b1;
        end
        if (wtdr && prev_tdre) begin
            m_tdr  = db_drv;
            m_tdre = 1'b0;
        end
        if (wctrl) m_ctrl = db_drv;
        // receiver: completions at scheduled cycles
        comp = 1'b0;
        c.c = 0; c.b = 8'h00; c.s = 1'b1;
        if (rx_q.size() > 0 && rx_q[0].c == cyc) begin
            c = rx_q.pop_front();
            comp = 1'b1;
        end
        if (comp) begin
            if (!m_rdrf || rd0) begin
                m_rdr  = c.b;
                m_rdrf = 1'b1;
                m_fe   = !c.s;
                if (rd0) m_or = 1'b0;
            end else begin
                m_or = 1'b1;
            end
        end else if (rd0) begin
            m_rdrf = 1'b0; m_or = 1'b0; m_fe = 1'b0;
        end
    endtask

    function automatic logic exp_txd();
        int k;
        if (!tx_busy) return 1'b1;
        k = (cyc - tx_start) / B;
        if (k == 0) return 1'b0;
        if (k <= 8) return tx_byte[k-1];
        return 1'b1;
    endfunction

    function automatic logic [7:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return m_rdr;
            2'd2:    return {m_tdre, m_tc, m_rdrf, 1'b0, m_or, 1'b0, m_fe, 1'b0};
            2'd3:    return m_ctrl;
            default: return 8'h00;
        endcase
    endfunction

    // model steps on every clock edge, resets asynchronously with the DUT
    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rstb);
            if (!rstb) model_reset();
            else model_edge();
        end
    end

    // per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (rstb && checking) begin
            check("txd", 32'(txd), 32'(exp_txd()));
            check("sciirq", 32'(sciirq), 32'((m_ctrl[6] && m_rdrf) || (m_ctrl[7] && m_tdre)));
            if (scisel && !rw) check("read_data", 32'(dbus), 32'(exp_rd(addr)));
            else if (db_oe) check("bus_hold", 32'(dbus), 32'(db_drv));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        scisel = 1'b1; rw = 1'b1; addr = a; db_drv = d; db_oe = 1'b1;
        @(posedge clk); #2;
        scisel = 1'b0; rw = 1'b0; db_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(posedge clk); #2;
        scisel = 1'b1; rw = 1'b0; addr = a;
        #4;
        d = dbus;
        @(posedge clk); #2;
        scisel = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int extra_low);
        comp_t c;
        @(posedge clk); #2;
        last_n0 = cyc + 1;
        c.c = last_n0 + 2 + B / 2 + 9 * B;
        c.b = b;
        c.s = stop;
        last_comp = c.c;
        rx_q.push_back(c);
        rxd = 1'b0;
        wait_cycles(B);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cycles(B);
        end
        rxd = stop;
        wait_cycles(B);
        if (!stop) begin
            rxd = 1'b0;
            if (extra_low > 0) wait_cycles(extra_low);
            rxd = 1'b1;
            wait_cycles(4);
        end
        rxd = 1'b1;
    endtask

    initial begin
        logic [7:0]  d;
        logic [19:0] pat;
        int          e0, k, target;
        logic        stop_b;
        n_checks = 0; n_fail = 0; checking = 1'b0; rx_phase_done = 1'b0;
        rstb = 1'b0; scisel = 1'b0; rw = 1'b0; addr = 2'd0;
        db_drv = 8'h00; db_oe = 1'b0; rxd = 1'b1;
        wait_cycles(3);
        rstb = 1'b1;
        checking = 1'b1;

        // reset state
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_irq", 32'(sciirq), 32'd0);
        bus_read(2'd2, d); check("reset_status", 32'(d), 32'hC0);
        bus_read(2'd3, d); check("reset_ctrl", 32'(d), 32'h00);
        bus_read(2'd0, d); check("reset_rdr", 32'(d), 32'h00);
        bus_read(2'd1, d); check("tdr_reads_zero", 32'(d), 32'h00);

        // receive with interrupt
        bus_write(2'd3, 8'h40);
        fork
            send_rx(8'hA5, 1'b1, 0);
            begin
                wait_cycles(2);
                k = 0;
                while (!sciirq && k < 200) begin @(negedge clk); k++; end
                check("irq_at_stop_mid", 32'(cyc - last_n0), 32'd78);
                bus_read(2'd0, d); check("rx_a5", 32'(d), 32'hA5);
                @(negedge clk);
                check("irq_clear", 32'(sciirq), 32'd0);
                bus_read(2'd2, d); check("status_after_read", 32'(d), 32'hC0);
            end
        join

        // back-to-back transmit
        bus_write(2'd1, 8'h3C);
        e0 = cyc;
        bus_write(2'd1, 8'hC3);
        pat = 20'b1110000110_1001111000;
        for (int i = 0; i < 20; i++) begin
            target = e0 + 1 + B * i + B / 2;
            while (cyc < target) begin @(posedge clk); #1; end
            check($sformatf("txd_bit%0d", i), 32'(txd), 32'(pat[i]));
        end
        bus_read(2'd2, d); check("tc_low_in_second_frame", 32'(d), 32'h80);
        wait_cycles(4);
        bus_read(2'd2, d); check("tc_after_second_stop", 32'(d), 32'hC0);

        // overrun
        send_rx(8'h11, 1'b1, 0);
        send_rx(8'h22, 1'b1, 0);
        bus_read(2'd2, d); check("overrun_status", 32'(d), 32'hE8);
        bus_read(2'd0, d); check("overrun_rdr", 32'(d), 32'h11);
        bus_read(2'd2, d); check("overrun_cleared", 32'(d), 32'hC0);

        // framing error and break wait, then a short glitch
        send_rx(8'h5A, 1'b0, 30);
        wait_cycles(90);
        bus_read(2'd2, d); check("framing_status", 32'(d), 32'hE2);
        bus_read(2'd0, d); check("framing_rdr", 32'(d), 32'h5A);
        bus_read(2'd2, d); check("framing_cleared", 32'(d), 32'hC0);
        rxd = 1'b0; wait_cycles(3); rxd = 1'b1;
        wait_cycles(100);
        bus_read(2'd2, d); check("glitch_no_rdrf", 32'(d), 32'hC0);

        // RDR read on the same edge as a completion
        send_rx(8'h77, 1'b1, 0);
        fork
            send_rx(8'h99, 1'b1, 0);
            begin
                wait_cycles(3);
                while (cyc < last_comp - 2) begin @(posedge clk); #1; end
                bus_read(2'd0, d); check("same_edge_old_byte", 32'(d), 32'h77);
            end
        join
        bus_read(2'd2, d); check("same_edge_status", 32'(d), 32'hE0);
        bus_read(2'd0, d); check("same_edge_new_byte", 32'(d), 32'h99);
        bus_read(2'd2, d); check("same_edge_cleared", 32'(d), 32'hC0);

        // randomized traffic on both directions
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    if ($urandom_range(0, 5) == 0) begin
                        rxd = 1'b0; wait_cycles(3); rxd = 1'b1; wait_cycles(8);
                    end
                    stop_b = ($urandom_range(0, 4) != 0);
                    send_rx(8'($urandom), stop_b, int'($urandom_range(0, 24)));
                    wait_cycles(int'($urandom_range(1, 10)));
                end
                rx_phase_done = 1'b1;
            end
            begin
                logic [7:0] rd;
                int         r;
                while (!rx_phase_done) begin
                    r = int'($urandom_range(0, 9));
                    if (r < 4) bus_read(2'($urandom_range(0, 3)), rd);
                    else if (r < 6) bus_write(2'd1, 8'($urandom));
                    else if (r == 6) bus_write(2'd3, 8'($urandom));
                    else if (r == 7) bus_write(($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2, 8'($urandom));
                    else wait_cycles(int'($urandom_range(1, 20)));
                end
            end
        join
        wait_cycles(200);

        // mid-frame reset aborts transmit and receive
        bus_write(2'd3, 8'h3F);
        bus_write(2'd1, 8'h00);
        rxd = 1'b0;
        wait_cycles(30);
        #1;
        rstb = 1'b0;
        #1;
        check("async_reset_txd", 32'(txd), 32'd1);
        rxd = 1'b1;
        wait_cycles(3);
        rstb = 1'b1;
        wait_cycles(100);
        bus_read(2'd2, d); check("post_reset_status", 32'(d), 32'hC0);
        bus_read(2'd3, d); check("post_reset_ctrl", 32'(d), 32'h00);
        bus_read(2'd0, d); check("post_reset_rdr", 32'(d), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
